// File: rtl/countdown_timer_pkg.sv
// Shared types for the loadable countdown timer.
package countdown_timer_pkg;

   // Two-state control FSM; encoding kept explicit so RUN decodes as a single bit.
   typedef enum logic {
      StIdle = 1'b0,
      StRun  = 1'b1
   } state_e;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with a one-cycle done pulse on expiry.
// Optional periodic auto-reload mode is built when COUNTDOWN_TIMER_AUTO_RELOAD_EN is defined:
// it adds the periodic input and a reload register holding the last loaded value.
module countdown_timer
   import countdown_timer_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             abort,
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
   input  logic             periodic,
`endif
   output logic             busy,
   output logic [WIDTH-1:0] cnt,
   output logic             zero,
   output logic             done
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
   logic [WIDTH-1:0] reload_q, reload_d;
`endif

   // Next-state logic: IDLE waits for start, RUN decrements with abort taking priority over en.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
      reload_d = reload_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (load_val != '0) begin
                  cnt_d   = load_val;
                  busy_d  = 1'b1;
                  state_d = StRun;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
                  reload_d = load_val;
`endif
               end else begin
                  // A zero-length count completes immediately without ever going busy.
                  cnt_d  = '0;
                  done_d = 1'b1;
               end
            end
         end
         StRun: begin
            if (abort) begin
               cnt_d   = '0;
               busy_d  = 1'b0;
               state_d = StIdle;
            end else if (en) begin
               if (cnt_q > WIDTH'(1)) begin
                  cnt_d = cnt_q - WIDTH'(1);
               end else begin
                  done_d = 1'b1;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
                  if (periodic) begin
                     cnt_d = reload_q;
                  end else begin
                     cnt_d   = '0;
                     busy_d  = 1'b0;
                     state_d = StIdle;
                  end
`else
                  cnt_d   = '0;
                  busy_d  = 1'b0;
                  state_d = StIdle;
`endif
               end
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State registers with asynchronous active-low reset; reset never produces done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
         reload_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
         reload_q <= reload_d;
`endif
      end
   end

   assign busy = busy_q;
   assign cnt  = cnt_q;
   assign done = done_q;
   assign zero = (cnt_q == '0);

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
Loadable down-counter: the count-down counterpart of the team's clear/enable up-counter.
- Accepts a start request with a load value and decrements on each enable.
- Signals completion with a one-cycle done pulse and drops busy.
- Sits beside the up-counter in timing/sequencing logic, e.g. timeouts and inter-event gaps.

Parameters:
WIDTH, 8, bit width of load_val and cnt

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  request to load load_val and begin counting; sampled only in IDLE
load_val  input  WIDTH  initial count, unsigned
en  input  1  decrement enable (tick), qualified only in RUN
abort  input  1  cancel a running count
busy  output  1  registered; high while in RUN
cnt  output  WIDTH  registered current count
zero  output  1  combinational, cnt == 0
done  output  1  registered one-cycle completion pulse

Behaviour:
- Reset is asynchronous, active-low: state=IDLE, cnt=0, busy=0, done=0, hence zero=1. Reset mid-count aborts silently; no done.
- Two-state FSM: IDLE, RUN.
- Default every cycle: done<=0.
- IDLE, start=1, load_val!=0: cnt<=load_val, busy<=1, go to RUN. The internal reload register captures load_val.
- IDLE, start=1, load_val==0: cnt stays 0, done<=1 on the next edge, busy stays 0, remain IDLE.
- IDLE, start=0: hold; en and abort are ignored.
- RUN priority order: abort > en.
  - abort=1: cnt<=0, busy<=0, go to IDLE, no done pulse.
  - en=1, cnt>1: cnt<=cnt-1.
  - en=1, cnt==1: cnt<=0, done<=1, busy<=0, go to IDLE.
  - en=0: hold.
- start during RUN is ignored; it does not restart.
- Latency with en held high: start sampled at edge t0 gives busy=1 and cnt=N after t0; cnt=0, done=1, busy=0 after edge t0+N.
- Back-to-back: start may be asserted in the cycle done is high. The FSM is already IDLE, so the new count loads on that edge.
- Arithmetic is unsigned. cnt never wraps below 0, because decrement only occurs when cnt>=1.
- Maximum load is 2^WIDTH-1.

Optional Feature:
Macro COUNTDOWN_TIMER_AUTO_RELOAD_EN.
- When defined:
  - Adds input periodic (1 bit).
  - In RUN, on en=1 with cnt==1 and periodic=1 and abort=0: done<=1, cnt<=reload register value, stay in RUN, busy stays 1.
  - This gives a periodic done every N enabled cycles.
  - periodic=0 behaves as without the macro.
  - abort still wins.
- When not defined: no periodic port, no reload register; always returns to IDLE on expiry.

Decomposition:
- Package countdown_timer_pkg holds the state typedef (IDLE=1'b0, RUN=1'b1).
- No sub-module: FSM, counter and reload register are small enough for one module.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, release -> cnt=0, busy=0, done=0, zero=1.
- Basic count: load_val=5, one-cycle start, en=1 continuous -> busy high for 5 cycles; cnt 5,4,3,2,1,0; done high exactly 1 cycle when cnt=0; busy=0 in the same cycle.
- Gated enable: load_val=3, en toggling 1,0,1,0,1 -> cnt holds on en=0 cycles; done after the 3rd en=1.
- Edge values: load_val=0 start -> done pulse next cycle, busy never rises. load_val=255 (WIDTH=8) -> done after 255 enables, no wrap.
- Abort and restart: load_val=10, abort at cnt=4 -> cnt=0, busy=0, no done. start in RUN ignored. start asserted in the done cycle reloads immediately.
- Auto-reload (macro defined): load_val=4, periodic=1, en=1 -> done every 4 cycles, busy stays 1. Drop periodic -> next expiry returns to IDLE. Async reset mid-count -> immediate IDLE, no done.
